breath_pwm: RTL and testbench
=============================

Name: breath_pwm

Overview:
Downstream consumer of the breath LED's periodic tick generator (1-cycle pulse every 2 ms at 50 MHz). Each tick steps a PWM duty value along a breathing profile: ramp up, hold bright, ramp down, hold dark, repeat. A free-running PWM counter at sys_clk rate converts the duty value to the LED drive. Duty changes take effect only at PWM period boundaries, so the output is glitch-free.

Parameters:
PWM_PERIOD, 1000, PWM period in sys_clk cycles (20 us at 50 MHz); legal range 2 .. 2^DUTY_W-1
DUTY_W, 16, width of duty and PWM counter
STEP, 10, duty increment/decrement per tick; legal range >=1
HOLD_TICKS, 50, ticks spent in each hold state; values 0 and 1 both mean one tick

Ports:
sys_clk  in  1  system clock, all logic on rising edge
sys_rst_n  in  1  asynchronous active-low reset
tick  in  1  single-cycle step pulse from the upstream tick generator
en  in  1  enable; low freezes the profile and blanks the LED
led  out  1  PWM output, registered, active high
duty  out  DUTY_W  current target duty (registered)
phase  out  2  state: 0 RISE, 1 HOLD_HI, 2 FALL, 3 HOLD_LO
breath_done  out  1  1-cycle pulse on each HOLD_LO->RISE transition

Behaviour:
- Reset (async, sys_rst_n low): phase=RISE, duty=0, duty_active=0, pwm_cnt=0, hold_cnt=0, led=0, breath_done=0.
- PWM counter: pwm_cnt counts 0..PWM_PERIOD-1 and wraps to 0. On the cycle pwm_cnt==PWM_PERIOD-1: duty_active <= duty.
- led <= en && (pwm_cnt < duty_active). duty_active=0 gives constant 0. duty_active=PWM_PERIOD gives constant 1.
- Profile FSM advances only on cycles with tick=1 and en=1. All other cycles hold the state.
- RISE: duty <= min(duty+STEP, PWM_PERIOD), computed in DUTY_W+1 bits with no wrap. When the new value equals PWM_PERIOD: go to HOLD_HI and load hold_cnt=HOLD_TICKS.
- HOLD_HI: on tick, if hold_cnt<=1 go to FALL, else hold_cnt decrements. Duty stays unchanged.
- FALL: duty <= (duty>STEP) ? duty-STEP : 0, saturating, no underflow. When the new value is 0: go to HOLD_LO and load hold_cnt=HOLD_TICKS.
- HOLD_LO: same countdown as HOLD_HI. On exit go to RISE and pulse breath_done=1 for exactly one cycle (the cycle after the tick).
- Latency:
  - tick at cycle N updates duty and phase at N+1.
  - The new duty reaches duty_active at the next pwm wrap.
  - led reflects it one cycle after that.
- en low:
  - led=0 on the next cycle.
  - pwm_cnt held at 0.
  - duty, phase and hold_cnt frozen.
  - Ticks are ignored.
- en rising: resumes from the frozen state. pwm_cnt restarts from 0, and duty_active reloads at the first wrap.
- tick and en falling in the same cycle: en wins and the tick is dropped.
- tick held high for several cycles: each high cycle counts as one tick. The upstream block guarantees single-cycle pulses.
- Reset mid-profile: everything returns to reset values immediately, with no partial PWM period.
- STEP larger than the remaining headroom: saturates to the limit in one tick, then changes state.

Test Plan:
- PWM_PERIOD=10, STEP=4, HOLD_TICKS=2, en=1, ticks spaced 20 cycles apart -> duty sequence 0,4,8,10. phase goes RISE->HOLD_HI on the 3rd tick and ->FALL on the 5th tick.
- Same params, continue ticking -> duty 10,6,2,0. Then HOLD_LO for 2 ticks, then RISE with breath_done high for exactly 1 cycle. Total cycle = 10 ticks.
- duty=4 (PWM_PERIOD=10) -> after the wrap, led is high for exactly 4 of every 10 cycles. duty 0 -> led never high. duty 10 -> led always high.
- Tick mid-period (pwm_cnt=3) with duty 4->8 -> led high-time stays 4 until pwm_cnt wraps, then 8. No pulse shorter than the old or new duty.
- en dropped during FALL at duty=6 with a tick in the same cycle -> led=0 next cycle and duty stays 6. After en is re-raised, the next tick gives duty=2.
- Reset asserted mid-HOLD_HI -> duty=0, phase=RISE, led=0 asynchronously. After release, the first tick gives duty=STEP.

Source files
------------

// File: rtl/breath_pwm.sv
// Breathing LED driver: each qualified tick steps a duty value through
// rise / hold-bright / fall / hold-dark, and a free-running PWM turns it into led.
module breath_pwm #(
    parameter int unsigned PWM_PERIOD = 1000,
    parameter int unsigned DUTY_W     = 16,
    parameter int unsigned STEP       = 10,
    parameter int unsigned HOLD_TICKS = 50
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              tick,
    input  logic              en,
    output logic              led,
    output logic [DUTY_W-1:0] duty,
    output logic [1:0]        phase,
    output logic              breath_done
);

    typedef enum logic [1:0] {
        RISE    = 2'd0,
        HOLD_HI = 2'd1,
        FALL    = 2'd2,
        HOLD_LO = 2'd3
    } phase_e;

    // A step wider than the whole period behaves exactly like a step of one period.
    localparam int unsigned STEP_SAT = (STEP > PWM_PERIOD) ? PWM_PERIOD : STEP;
    localparam int unsigned HOLD_W   = (HOLD_TICKS < 2) ? 1 : $clog2(HOLD_TICKS + 1);

    localparam logic [DUTY_W:0]   PERIOD_X   = (DUTY_W + 1)'(PWM_PERIOD);
    localparam logic [DUTY_W:0]   STEP_X     = (DUTY_W + 1)'(STEP_SAT);
    localparam logic [DUTY_W-1:0] STEP_D     = DUTY_W'(STEP_SAT);
    localparam logic [DUTY_W-1:0] PERIOD_MAX = DUTY_W'(PWM_PERIOD);
    localparam logic [DUTY_W-1:0] PWM_LAST   = DUTY_W'(PWM_PERIOD - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(HOLD_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);

    phase_e            phase_q;
    logic [DUTY_W-1:0] duty_q;
    logic [DUTY_W-1:0] duty_active_q;
    logic [DUTY_W-1:0] pwm_cnt_q;
    logic [DUTY_W-1:0] pwm_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic              led_q;
    logic              breath_done_q;

    logic [DUTY_W:0]   rise_sum_d;
    logic [DUTY_W-1:0] fall_diff_d;
    logic              rise_top;
    logic              fall_zero;
    logic              hold_last;
    logic              step;
    logic              pwm_wrap;

    always_comb begin
        rise_sum_d  = {1'b0, duty_q} + STEP_X;
        rise_top    = (rise_sum_d >= PERIOD_X);
        fall_zero   = ({1'b0, duty_q} <= STEP_X);
        fall_diff_d = duty_q - STEP_D;
        hold_last   = (hold_cnt_q <= HOLD_ONE);
        step        = tick & en;
        pwm_wrap    = (pwm_cnt_q == PWM_LAST);
        pwm_cnt_d   = pwm_wrap ? '0 : pwm_cnt_q + 1'b1;
    end

    // Profile FSM; only a tick seen while enabled moves it.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            phase_q       <= RISE;
            duty_q        <= '0;
            hold_cnt_q    <= '0;
            breath_done_q <= 1'b0;
        end else begin
            breath_done_q <= 1'b0;
            if (step) begin
                case (phase_q)
                    RISE: begin
                        if (rise_top) begin
                            duty_q     <= PERIOD_MAX;
                            phase_q    <= HOLD_HI;
                            hold_cnt_q <= HOLD_LOAD;
                        end else begin
                            duty_q <= rise_sum_d[DUTY_W-1:0];
                        end
                    end
                    HOLD_HI: begin
                        if (hold_last) begin
                            phase_q <= FALL;
                        end else begin
                            hold_cnt_q <= hold_cnt_q - HOLD_ONE;
                        end
                    end
                    FALL: begin
                        if (fall_zero) begin
                            duty_q     <= '0;
                            phase_q    <= HOLD_LO;
                            hold_cnt_q <= HOLD_LOAD;
                        end else begin
                            duty_q <= fall_diff_d;
                        end
                    end
                    HOLD_LO: begin
                        if (hold_last) begin
                            phase_q       <= RISE;
                            breath_done_q <= 1'b1;
                        end else begin
                            hold_cnt_q <= hold_cnt_q - HOLD_ONE;
                        end
                    end
                    default: phase_q <= RISE;
                endcase
            end
        end
    end

    // Duty is only sampled into duty_active at the period boundary, so no pulse is ever cut short.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pwm_cnt_q     <= '0;
            duty_active_q <= '0;
            led_q         <= 1'b0;
        end else if (!en) begin
            pwm_cnt_q <= '0;
            led_q     <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            if (pwm_wrap) begin
                duty_active_q <= duty_q;
            end
            led_q <= (pwm_cnt_q < duty_active_q);
        end
    end

    assign led         = led_q;
    assign duty        = duty_q;
    assign phase       = phase_q;
    assign breath_done = breath_done_q;

endmodule

// File: tb/tb_breath_pwm.sv
// Directed bench for breath_pwm with a short period (10), step 4 and two-tick holds.
module tb_breath_pwm;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        tick;
    logic        en;
    logic        led;
    logic [15:0] duty;
    logic [1:0]  phase;
    logic        breath_done;

    int n_tests;
    int n_fail;

    logic [15:0] exp_q[$];

    breath_pwm #(
        .PWM_PERIOD(10),
        .DUTY_W    (16),
        .STEP      (4),
        .HOLD_TICKS(2)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .tick       (tick),
        .en         (en),
        .led        (led),
        .duty       (duty),
        .phase      (phase),
        .breath_done(breath_done)
    );

    // clock / reset
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // one-cycle tick, driven on falling edges; returns just after the sampling edge
    task automatic do_tick();
        @(negedge sys_clk);
        tick = 1'b1;
        @(negedge sys_clk);
        tick = 1'b0;
    endtask

    // let a new duty reach led, then count led-high cycles over one period
    task automatic led_high_count(output int cnt);
        cnt = 0;
        repeat (10) @(negedge sys_clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            if (led) cnt++;
        end
    endtask

    initial begin
        int          hc;
        int          c1;
        int          c2;
        logic        prev;
        logic        found;
        logic [15:0] e;
        logic [1:0]  prof_phase[10];
        logic [15:0] prof_duty[10];

        prof_duty  = '{16'd4, 16'd8, 16'd10, 16'd10, 16'd10, 16'd6, 16'd2, 16'd0, 16'd0, 16'd0};
        prof_phase = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
        for (int i = 0; i < 10; i++) exp_q.push_back(prof_duty[i]);

        n_tests   = 0;
        n_fail    = 0;
        tick      = 1'b0;
        en        = 1'b0;
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("rst_duty", 32'(duty), 32'd0);
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_led", 32'(led), 32'd0);
        check("rst_done", 32'(breath_done), 32'd0);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        en = 1'b1;

        led_high_count(hc);
        check("led_cnt_duty0", 32'(hc), 32'd0);

        // tick 1: duty 0 -> 4, then 4 of every 10 cycles high
        do_tick();
        e = exp_q.pop_front();
        check("t1_duty", 32'(duty), 32'(e));
        check("t1_phase", 32'(phase), 32'(prof_phase[0]));
        led_high_count(hc);
        check("led_cnt_duty4", 32'(hc), 32'd4);

        // tick 2 lands at pwm_cnt=3: current period keeps 4, next period gets 8
        found = 1'b0;
        prev  = led;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge sys_clk);
            if (led && !prev) found = 1'b1;
            prev = led;
        end
        check("led_rise_found", 32'(found), 32'd1);
        c1 = 0;
        c2 = 0;
        for (int j = 0; j < 20; j++) begin
            if (j > 0) @(negedge sys_clk);
            if (j < 10) c1 += int'(led);
            else        c2 += int'(led);
            if (j == 2) tick = 1'b1;
            if (j == 3) tick = 1'b0;
        end
        check("mid_old_period", 32'(c1), 32'd4);
        check("mid_new_period", 32'(c2), 32'd8);
        e = exp_q.pop_front();
        check("t2_duty", 32'(duty), 32'(e));
        check("t2_phase", 32'(phase), 32'(prof_phase[1]));

        // rest of the first breath
        for (int k = 2; k < 10; k++) begin
            do_tick();
            e = exp_q.pop_front();
            check($sformatf("t%0d_duty", k + 1), 32'(duty), 32'(e));
            check($sformatf("t%0d_phase", k + 1), 32'(phase), 32'(prof_phase[k]));
            check($sformatf("t%0d_done", k + 1), 32'(breath_done), (k == 9) ? 32'd1 : 32'd0);
            if (k == 9) begin
                @(negedge sys_clk);
                check("done_one_cycle", 32'(breath_done), 32'd0);
            end
            led_high_count(hc);
            check($sformatf("t%0d_led_cnt", k + 1), 32'(hc), 32'(e));
        end

        // second breath up to FALL at duty 6
        for (int k = 0; k < 6; k++) do_tick();
        check("b2_duty6", 32'(duty), 32'd6);
        check("b2_fall", 32'(phase), 32'd2);

        // en drops in the same cycle as a tick: tick is lost
        @(negedge sys_clk);
        tick = 1'b1;
        en   = 1'b0;
        @(negedge sys_clk);
        tick = 1'b0;
        check("en_off_led", 32'(led), 32'd0);
        check("en_off_duty", 32'(duty), 32'd6);
        check("en_off_phase", 32'(phase), 32'd2);
        do_tick();
        check("en_off_tick_ignored", 32'(duty), 32'd6);
        hc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge sys_clk);
            if (led) hc++;
        end
        check("en_off_led_dark", 32'(hc), 32'd0);

        @(negedge sys_clk);
        en = 1'b1;
        repeat (3) @(negedge sys_clk);
        do_tick();
        check("en_on_duty2", 32'(duty), 32'd2);
        check("en_on_phase", 32'(phase), 32'd2);
        led_high_count(hc);
        check("en_on_led_cnt", 32'(hc), 32'd2);

        // on to HOLD_HI, then reset mid-hold
        for (int k = 0; k < 6; k++) do_tick();
        check("b3_hold_hi", 32'(phase), 32'd1);
        check("b3_duty10", 32'(duty), 32'd10);
        repeat (12) @(negedge sys_clk);
        check("b3_led_on", 32'(led), 32'd1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("arst_duty", 32'(duty), 32'd0);
        check("arst_phase", 32'(phase), 32'd0);
        check("arst_led", 32'(led), 32'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        do_tick();
        check("post_rst_duty", 32'(duty), 32'd4);
        check("post_rst_phase", 32'(phase), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
